csr_hpm_unit: RTL and testbench
===============================

// Module: csr_hpm_unit
// PURPOSE
//  Parametrised counter CSR bank: mcycle, minstret, NUM_HPM mhpmcounterN/mhpmeventN, mcountinhibit.
//  Event-selectable counting, per-counter inhibit and sticky overflow flags drive an overflow
//  interrupt request. Writes arrive from WB; reads are served combinationally to ID.
//  The owning CSR file muxes csr_val_id in on csr_hit_id and ORs ovf_irq into mip.
// PARAMETERS
//  NUM_HPM    4   implemented mhpmcounter3..(2+NUM_HPM); legal range 1..29
//  CNT_W      64  counter width for all counters; legal range 32..64
//  NUM_EVENTS 8   width of events_in; legal range 1..255
//  EVT_SEL_W  8   width of mhpmevent select field; 2**EVT_SEL_W > NUM_EVENTS
// PORTS
//  clk          in   1           clock
//  rst          in   1           synchronous active-high reset
//  csr_we_wb    in   1           CSR write strobe at WB
//  csr_addr_wb  in   12          CSR write address
//  csr_val_wb   in   64          CSR write data
//  csr_addr_id  in   12          CSR read address from ID
//  csr_val_id   out  64          read data, zero-extended from CNT_W
//  csr_hit_id   out  1           csr_addr_id decodes to a CSR owned by this block
//  retire_wb    in   1           one instruction retires this cycle (valid_wb & ~switch_mode)
//  events_in    in   NUM_EVENTS  per-cycle event pulses; bit k-1 is event k
//  ovf_irq      out  1           counter-overflow interrupt request (level)
// BEHAVIOUR
//  Clock is clk. Reset is synchronous and active-high on rst.
//  - Reset: all counters, mhpmevent fields and mcountinhibit = 0; ovf_irq = 0.
//  - Address map:
//    - mcycle 0xB00, minstret 0xB02, mhpmcounterN 0xB00+N (N=3..31).
//    - mcountinhibit 0x320, mhpmeventN 0x320+N.
//    - Read-only aliases: cycle 0xC00, instret 0xC02, hpmcounterN 0xC00+N.
//    - Writes to 0xCxx are ignored.
//  - Unimplemented N (N >= 3+NUM_HPM) and 0xB01/0xC01: hit=1, read 0, writes ignored.
//  - Any other address: hit=0, csr_val_id=0.
//  - mcountinhibit: bit0=CY, bit2=IR, bit(3+i)=HPM i. Bit1 and unimplemented bits read 0.
//  - Increment rules, one per cycle, all counters in parallel:
//    - mcycle +1 every cycle unless CY.
//    - minstret +1 when retire_wb & ~IR.
//    - hpm i +1 when sel_i in 1..NUM_EVENTS & events_in[sel_i-1] & ~HPM i.
//    - sel_i=0 or sel_i>NUM_EVENTS counts nothing.
//  - Counters wrap modulo 2**CNT_W. Writes keep csr_val_wb[CNT_W-1:0].
//  - Write vs increment in the same cycle: the write wins; that cycle's increment is dropped.
//  - A write to mcountinhibit governs counting from the next cycle on.
//    The write cycle itself counts under the old value.
//  - mhpmeventN stored bits:
//    - [EVT_SEL_W-1:0] sel.
//    - bit62 OVFIE (overflow interrupt enable).
//    - bit63 OF (sticky overflow).
//    - All other bits read 0.
//  - Overflow: hpm i incrementing from all-ones to 0 sets OF_i on the same edge.
//    A write-wins cycle sets no OF.
//    OF is cleared only by a software write of 0 to bit63.
//    If that write coincides with an overflow of counter i, OF_i ends set.
//  - ovf_irq = |(OF & OVFIE), driven from registers: high the cycle after the wrap edge.
//    ovf_irq stays high until software clears OF or OVFIE. mcycle/minstret have no OF.
//  - Read path is combinational from current registers, with no WB->ID bypass.
//    A same-cycle write is visible to ID on the next cycle.
//  - Reset asserted mid-count wins over every write and increment.
// TESTING
//  - Reset, then read 0xB00 twice, 5 cycles apart -> 0 then 5.
//    Read 0xB03 -> 0. ovf_irq=0. Read 0x7C0 -> hit=0.
//  - Write mcountinhibit=0x1 at cycle t.
//    -> mcycle advances at edge t and then freezes.
//    Write 0 -> mcycle resumes the next cycle. Read 0x320 after writing all-ones -> bit1=0.
//  - mhpmevent3 sel=2; pulse events_in[1] on 3 cycles and events_in[0] on 4 -> hpmcounter3 (0xC03) = 3.
//    Also set sel=0 and sel=NUM_EVENTS+1 -> counter holds.
//  - Write mhpmcounter3=2**CNT_W-2 and event3 = OVFIE|sel=1; hold events_in[0]=1.
//    -> after 2 increments counter=0, OF=1, ovf_irq=1 one cycle later.
//    Further wraps keep OF=1. Writing bit63=0 drops ovf_irq the next cycle.
//  - Write mhpmcounter3=0x10 in a cycle where its event fires -> reads 0x10, not 0x11.
//    Clearing OF in the same cycle as an overflow -> OF reads 1.
//  - Write 0xB1F and 0xC00 -> no state change, read 0. Assert rst mid-count -> all reads 0 the next cycle.

Source files
------------

// File: rtl/csr_hpm_unit.sv
// Performance-counter CSR bank: mcycle, minstret, mhpmcounterN/mhpmeventN and mcountinhibit.
// All counters advance in parallel each cycle; sticky per-counter overflow flags drive ovf_irq.
module csr_hpm_unit #(
    parameter int NUM_HPM    = 4,
    parameter int CNT_W      = 64,
    parameter int NUM_EVENTS = 8,
    parameter int EVT_SEL_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csr_we_wb,
    input  logic [11:0]           csr_addr_wb,
    input  logic [63:0]           csr_val_wb,
    input  logic [11:0]           csr_addr_id,
    output logic [63:0]           csr_val_id,
    output logic                  csr_hit_id,
    input  logic                  retire_wb,
    input  logic [NUM_EVENTS-1:0] events_in,
    output logic                  ovf_irq
);
    // Address groups are 32-entry windows selected by addr[11:5].
    localparam logic [6:0] GRP_MCNT = 7'h58;  // 0xB00..0xB1F
    localparam logic [6:0] GRP_UCNT = 7'h60;  // 0xC00..0xC1F
    localparam logic [6:0] GRP_MEVT = 7'h19;  // 0x320..0x33F

    localparam logic [31:0]      INH_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]     mcycle_q;
    logic [CNT_W-1:0]     minstret_q;
    logic [CNT_W-1:0]     hpm_cnt_q [NUM_HPM];
    logic [EVT_SEL_W-1:0] hpm_sel_q [NUM_HPM];
    logic [NUM_HPM-1:0]   hpm_ovfie_q;
    logic [NUM_HPM-1:0]   hpm_of_q;
    logic [31:0]          inhibit_q;

    logic                 wr_cnt;
    logic                 wr_evt;
    logic [4:0]           wr_idx;
    logic [6:0]           rd_grp;
    logic [4:0]           rd_idx;
    logic [NUM_HPM-1:0]   evt_hit;
    logic [NUM_HPM-1:0]   hpm_inc;
    logic [NUM_HPM-1:0]   hpm_cnt_wr;
    logic [NUM_HPM-1:0]   hpm_evt_wr;
    logic [NUM_HPM-1:0]   hpm_wrap;

    // Only machine-mode windows are writable; the 0xCxx aliases are read-only.
    assign wr_cnt = csr_we_wb && (csr_addr_wb[11:5] == GRP_MCNT);
    assign wr_evt = csr_we_wb && (csr_addr_wb[11:5] == GRP_MEVT);
    assign wr_idx = csr_addr_wb[4:0];
    assign rd_grp = csr_addr_id[11:5];
    assign rd_idx = csr_addr_id[4:0];

    always_comb begin
        evt_hit    = '0;
        hpm_inc    = '0;
        hpm_cnt_wr = '0;
        hpm_evt_wr = '0;
        hpm_wrap   = '0;
        for (int i = 0; i < NUM_HPM; i++) begin
            for (int k = 1; k <= NUM_EVENTS; k++) begin
                if ((hpm_sel_q[i] == EVT_SEL_W'(k)) && events_in[k-1]) begin
                    evt_hit[i] = 1'b1;
                end
            end
            hpm_cnt_wr[i] = wr_cnt && (wr_idx == 5'(i + 3));
            hpm_evt_wr[i] = wr_evt && (wr_idx == 5'(i + 3));
            hpm_inc[i]    = evt_hit[i] && !inhibit_q[3+i];
            // A write to the counter suppresses both the increment and the overflow.
            hpm_wrap[i]   = hpm_inc[i] && !hpm_cnt_wr[i] && (&hpm_cnt_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q    <= '0;
            minstret_q  <= '0;
            inhibit_q   <= '0;
            hpm_ovfie_q <= '0;
            hpm_of_q    <= '0;
            for (int i = 0; i < NUM_HPM; i++) begin
                hpm_cnt_q[i] <= '0;
                hpm_sel_q[i] <= '0;
            end
        end else begin
            if (wr_cnt && (wr_idx == 5'd0)) begin
                mcycle_q <= csr_val_wb[CNT_W-1:0];
            end else if (!inhibit_q[0]) begin
                mcycle_q <= mcycle_q + CNT_ONE;
            end

            if (wr_cnt && (wr_idx == 5'd2)) begin
                minstret_q <= csr_val_wb[CNT_W-1:0];
            end else if (retire_wb && !inhibit_q[2]) begin
                minstret_q <= minstret_q + CNT_ONE;
            end

            if (wr_evt && (wr_idx == 5'd0)) begin
                inhibit_q <= csr_val_wb[31:0] & INH_MASK;
            end

            for (int i = 0; i < NUM_HPM; i++) begin
                if (hpm_cnt_wr[i]) begin
                    hpm_cnt_q[i] <= csr_val_wb[CNT_W-1:0];
                end else if (hpm_inc[i]) begin
                    hpm_cnt_q[i] <= hpm_cnt_q[i] + CNT_ONE;
                end
                // A coincident wrap beats a software clear of OF.
                if (hpm_evt_wr[i]) begin
                    hpm_sel_q[i]   <= csr_val_wb[EVT_SEL_W-1:0];
                    hpm_ovfie_q[i] <= csr_val_wb[62];
                    hpm_of_q[i]    <= csr_val_wb[63] | hpm_wrap[i];
                end else if (hpm_wrap[i]) begin
                    hpm_of_q[i]    <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        csr_hit_id = 1'b0;
        csr_val_id = '0;
        if ((rd_grp == GRP_MCNT) || (rd_grp == GRP_UCNT)) begin
            csr_hit_id = 1'b1;
            if (rd_idx == 5'd0) csr_val_id = 64'(mcycle_q);
            if (rd_idx == 5'd2) csr_val_id = 64'(minstret_q);
            for (int i = 0; i < NUM_HPM; i++) begin
                if (rd_idx == 5'(i + 3)) csr_val_id = 64'(hpm_cnt_q[i]);
            end
        end else if (rd_grp == GRP_MEVT) begin
            // 0x321/0x322 are not part of this bank.
            csr_hit_id = (rd_idx != 5'd1) && (rd_idx != 5'd2);
            if (rd_idx == 5'd0) csr_val_id = 64'(inhibit_q);
            for (int i = 0; i < NUM_HPM; i++) begin
                if (rd_idx == 5'(i + 3)) begin
                    csr_val_id[63]            = hpm_of_q[i];
                    csr_val_id[62]            = hpm_ovfie_q[i];
                    csr_val_id[EVT_SEL_W-1:0] = hpm_sel_q[i];
                end
            end
        end
    end

    assign ovf_irq = |(hpm_of_q & hpm_ovfie_q);

endmodule

// File: tb/tb_csr_hpm_unit.sv
// Directed bench for csr_hpm_unit: reads push {hit, irq, val} expectations, a negedge monitor checks them.
module tb_csr_hpm_unit;
  localparam int NUM_HPM    = 4;
  localparam int CNT_W      = 64;
  localparam int NUM_EVENTS = 8;
  localparam int EVT_SEL_W  = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  csr_we_wb = 1'b0;
  logic [11:0]           csr_addr_wb = '0;
  logic [63:0]           csr_val_wb = '0;
  logic [11:0]           csr_addr_id = '0;
  logic [63:0]           csr_val_id;
  logic                  csr_hit_id;
  logic                  retire_wb = 1'b0;
  logic [NUM_EVENTS-1:0] events_in = '0;
  logic                  ovf_irq;

  // rd_req marks a cycle whose read result the monitor must check.
  logic        rd_req = 1'b0;
  logic [65:0] exp_q[$];
  string       name_q[$];
  logic [65:0] mon_exp;
  string       mon_nm;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  csr_hpm_unit #(
    .NUM_HPM(NUM_HPM), .CNT_W(CNT_W), .NUM_EVENTS(NUM_EVENTS), .EVT_SEL_W(EVT_SEL_W)
  ) dut (
    .clk(clk), .rst(rst),
    .csr_we_wb(csr_we_wb), .csr_addr_wb(csr_addr_wb), .csr_val_wb(csr_val_wb),
    .csr_addr_id(csr_addr_id), .csr_val_id(csr_val_id), .csr_hit_id(csr_hit_id),
    .retire_wb(retire_wb), .events_in(events_in), .ovf_irq(ovf_irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] v);
    csr_we_wb   = 1'b1;
    csr_addr_wb = a;
    csr_val_wb  = v;
    tick();
    csr_we_wb   = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [11:0] a, input logic [63:0] v,
                    input logic hit, input logic irq);
    csr_addr_id = a;
    exp_q.push_back({hit, irq, v});
    name_q.push_back(nm);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rd_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor_underflow: read with no expectation queued");
      end else begin
        mon_exp = exp_q.pop_front();
        mon_nm  = name_q.pop_front();
        if ({csr_hit_id, ovf_irq, csr_val_id} !== mon_exp) begin
          errors++;
          $display("FAIL %s: got hit=%0b irq=%0b val=%h, want hit=%0b irq=%0b val=%h",
                   mon_nm, csr_hit_id, ovf_irq, csr_val_id, mon_exp[65], mon_exp[64], mon_exp[63:0]);
        end
      end
    end
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;

    // Reset state and free-running mcycle
    rd("mcycle_reset", 12'hB00, 64'd0, 1'b1, 1'b0);
    repeat (4) tick();
    rd("mcycle_5", 12'hB00, 64'd5, 1'b1, 1'b0);
    rd("hpm3_reset", 12'hB03, 64'd0, 1'b1, 1'b0);
    rd("unmapped_7c0", 12'h7C0, 64'd0, 1'b0, 1'b0);
    retire_wb = 1'b1;
    repeat (2) tick();
    retire_wb = 1'b0;
    rd("instret_2", 12'hC02, 64'd2, 1'b1, 1'b0);
    rd("cycle_alias", 12'hC00, 64'd11, 1'b1, 1'b0);

    // mcountinhibit timing: write cycle counts under the old value
    wr(12'h320, 64'h1);
    rd("cy_frozen_a", 12'hB00, 64'd13, 1'b1, 1'b0);
    repeat (3) tick();
    rd("cy_frozen_b", 12'hB00, 64'd13, 1'b1, 1'b0);
    wr(12'h320, 64'h0);
    rd("cy_resume_a", 12'hB00, 64'd13, 1'b1, 1'b0);
    rd("cy_resume_b", 12'hB00, 64'd14, 1'b1, 1'b0);
    wr(12'h320, 64'hFFFF_FFFF_FFFF_FFFF);
    rd("inhibit_mask", 12'h320, 64'h7D, 1'b1, 1'b0);
    rd("cy_all_inh", 12'hB00, 64'd16, 1'b1, 1'b0);
    wr(12'h320, 64'h5);

    // Event selection
    wr(12'h323, 64'd2);
    for (int c = 0; c < 7; c++) begin
      events_in = (c < 3) ? 8'h02 : 8'h01;
      tick();
    end
    events_in = '0;
    rd("hpm3_sel2", 12'hC03, 64'd3, 1'b1, 1'b0);
    wr(12'h323, 64'd0);
    events_in = 8'hFF;
    repeat (2) tick();
    events_in = '0;
    rd("hpm3_sel0", 12'hB03, 64'd3, 1'b1, 1'b0);
    wr(12'h323, 64'd9);
    events_in = 8'hFF;
    repeat (2) tick();
    events_in = '0;
    rd("hpm3_sel9", 12'hB03, 64'd3, 1'b1, 1'b0);
    rd("event3_sel9", 12'h323, 64'd9, 1'b1, 1'b0);
    wr(12'h323, 64'd8);
    events_in = 8'h80;
    tick();
    events_in = 8'h7F;
    tick();
    events_in = '0;
    rd("hpm3_sel8", 12'hB03, 64'd4, 1'b1, 1'b0);
    wr(12'h320, 64'hD);
    events_in = 8'h80;
    repeat (2) tick();
    events_in = '0;
    rd("hpm3_inhibit", 12'hB03, 64'd4, 1'b1, 1'b0);
    wr(12'h320, 64'h5);

    // Overflow and sticky OF
    wr(12'h323, 64'h4000_0000_0000_0001);
    wr(12'hB03, 64'hFFFF_FFFF_FFFF_FFFE);
    events_in = 8'h01;
    rd("ovf_pre_a", 12'hB03, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
    rd("ovf_pre_b", 12'hB03, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    rd("ovf_wrap", 12'hB03, 64'd0, 1'b1, 1'b1);
    rd("ovf_of_set", 12'h323, 64'hC000_0000_0000_0001, 1'b1, 1'b1);
    wr(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
    rd("ovf_rewrap_a", 12'hB03, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    rd("ovf_rewrap_b", 12'hB03, 64'd0, 1'b1, 1'b1);
    events_in = '0;
    wr(12'h323, 64'h4000_0000_0000_0001);
    rd("of_cleared", 12'h323, 64'h4000_0000_0000_0001, 1'b1, 1'b0);
    rd("cnt_after_clr", 12'hB03, 64'd1, 1'b1, 1'b0);

    // Write beats increment; write-wins cycle sets no OF; wrap beats OF clear
    events_in = 8'h01;
    wr(12'hB03, 64'h10);
    events_in = '0;
    rd("write_wins", 12'hB03, 64'h10, 1'b1, 1'b0);
    wr(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
    events_in = 8'h01;
    wr(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
    events_in = '0;
    rd("no_of_on_write", 12'h323, 64'h4000_0000_0000_0001, 1'b1, 1'b0);
    rd("cnt_held_ones", 12'hB03, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    events_in = 8'h01;
    wr(12'h323, 64'h4000_0000_0000_0001);
    events_in = '0;
    rd("clr_vs_wrap", 12'h323, 64'hC000_0000_0000_0001, 1'b1, 1'b1);
    rd("clr_vs_wrap_cnt", 12'hB03, 64'd0, 1'b1, 1'b1);
    wr(12'h323, 64'h8000_0000_0000_0001);
    rd("of_no_ovfie", 12'h323, 64'h8000_0000_0000_0001, 1'b1, 1'b0);

    // Ignored writes and unimplemented addresses
    wr(12'hB1F, 64'h55);
    wr(12'hC00, 64'h77);
    rd("unimpl_b1f", 12'hB1F, 64'd0, 1'b1, 1'b0);
    rd("c00_ro", 12'hC00, 64'd16, 1'b1, 1'b0);
    rd("b01_hole", 12'hB01, 64'd0, 1'b1, 1'b0);
    rd("c01_hole", 12'hC01, 64'd0, 1'b1, 1'b0);
    rd("unimpl_b07", 12'hB07, 64'd0, 1'b1, 1'b0);
    rd("unimpl_evt_33f", 12'h33F, 64'd0, 1'b1, 1'b0);

    // Reset mid-count beats a coincident write and increments
    wr(12'h320, 64'h0);
    repeat (3) tick();
    rst         = 1'b1;
    csr_we_wb   = 1'b1;
    csr_addr_wb = 12'hB00;
    csr_val_wb  = 64'h1234;
    events_in   = 8'hFF;
    retire_wb   = 1'b1;
    tick();
    rst         = 1'b0;
    csr_we_wb   = 1'b0;
    events_in   = '0;
    retire_wb   = 1'b0;
    rd("rst_mcycle", 12'hB00, 64'd0, 1'b1, 1'b0);
    rd("rst_hpm3", 12'hB03, 64'd0, 1'b1, 1'b0);
    rd("rst_event3", 12'h323, 64'd0, 1'b1, 1'b0);
    rd("rst_inhibit", 12'h320, 64'd0, 1'b1, 1'b0);
    rd("rst_instret", 12'hC02, 64'd0, 1'b1, 1'b0);

    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
